// File: rtl/video_timing.sv
// Free-running raster timing generator that pulls pixels from a valid/ready source and drives a
// registered {R,G,B,DE,HSYNC,VSYNC} bus. Define VIDEO_TIMING_COLORBAR_EN for a colour-bar underflow fill.
module video_timing #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,  // >= 64 leaves room for the encoder's data island
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [23:0] pix_rgb,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [26:0] dd1,
  output logic        sof,
  output logic        underflow
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          h_last;
  logic          v_last;
  logic          de;
  logic          hs;
  logic          vs;
  logic          frame_start;
  logic [23:0]   fill_rgb;
  logic [23:0]   rgb_next;

  // Raster decode of the current source position
  always_comb begin
    h_last      = (hc == HW'(H_TOTAL - 1));
    v_last      = (vc == VW'(V_TOTAL - 1));
    de          = (hc < HW'(H_ACTIVE)) && (vc < VW'(V_ACTIVE));
    hs          = (hc >= HW'(HS_START)) && (hc < HW'(HS_END));
    vs          = (vc >= VW'(VS_START)) && (vc < VW'(VS_END));
    frame_start = (hc == '0) && (vc == '0);
  end

  assign pix_ready = de;

  // Pixel source select: upstream pixel, underflow fill, or black in blanking
  always_comb begin
    rgb_next = 24'h000000;
    if (de) begin
      rgb_next = pix_valid ? pix_rgb : fill_rgb;
    end
  end

  // Horizontal / vertical counters; vc advances on the hc wrap
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      hc <= '0;
      vc <= '0;
    end else if (h_last) begin
      hc <= '0;
      vc <= v_last ? '0 : vc + VW'(1);
    end else begin
      hc <= hc + HW'(1);
    end
  end

  // Registered video bus, frame marker and sticky underflow (set beats the sof clear)
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      dd1       <= '0;
      sof       <= 1'b0;
      underflow <= 1'b0;
    end else begin
      dd1 <= {rgb_next, de, hs, vs};
      sof <= frame_start;
      if (de && !pix_valid) begin
        underflow <= 1'b1;
      end else if (frame_start) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef VIDEO_TIMING_COLORBAR_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned PW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [PW-1:0] bar_pos;
  logic [3:0]    bar_idx;  // 8 marks the leftover pixels past the last bar

  // Bar stepping across the active part of the line, restarted for every hc=0
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (h_last) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if ((hc < HW'(H_ACTIVE)) && (bar_idx < 4'd8)) begin
      if (bar_pos == PW'(BAR_W - 1)) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 4'd1;
      end else begin
        bar_pos <= bar_pos + PW'(1);
      end
    end
  end

  always_comb begin
    fill_rgb = 24'h000000;
    if (BAR_W != 0) begin
      case (bar_idx)
        4'd0:    fill_rgb = 24'hFFFFFF;
        4'd1:    fill_rgb = 24'hFFFF00;
        4'd2:    fill_rgb = 24'h00FFFF;
        4'd3:    fill_rgb = 24'h00FF00;
        4'd4:    fill_rgb = 24'hFF00FF;
        4'd5:    fill_rgb = 24'hFF0000;
        4'd6:    fill_rgb = 24'h0000FF;
        default: fill_rgb = 24'h000000;
      endcase
    end
  end
`else
  always_comb begin
    fill_rgb = 24'h000000;
  end
`endif

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: small raster, underflow, colour bars, mid-frame reset, 720p line period.
`timescale 1ns/1ps
module tb_video_timing;

  logic        clk = 1'b0;
  logic        resetq;
  logic [23:0] rgb;
  logic        valid;
  logic        ready;
  logic [26:0] dd1;
  logic        sof;
  logic        uf;

  logic [23:0] cb_rgb;
  logic        cb_valid;
  logic        cb_ready;
  logic [26:0] cb_dd1;
  logic        cb_sof;
  logic        cb_uf;

  logic        hd_ready;
  logic [26:0] hd_dd1;
  logic        hd_sof;
  logic        hd_uf;

  int errors = 0;
  int checks = 0;

`ifdef VIDEO_TIMING_COLORBAR_EN
  localparam bit CB_EN = 1'b1;
`else
  localparam bit CB_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  video_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
                 .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)) dut (
    .clk(clk), .resetq(resetq), .pix_rgb(rgb), .pix_valid(valid),
    .pix_ready(ready), .dd1(dd1), .sof(sof), .underflow(uf));

  video_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
                 .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)) cb_dut (
    .clk(clk), .resetq(resetq), .pix_rgb(cb_rgb), .pix_valid(cb_valid),
    .pix_ready(cb_ready), .dd1(cb_dd1), .sof(cb_sof), .underflow(cb_uf));

  video_timing hd_dut (
    .clk(clk), .resetq(resetq), .pix_rgb(rgb), .pix_valid(valid),
    .pix_ready(hd_ready), .dd1(hd_dd1), .sof(hd_sof), .underflow(hd_uf));

  typedef struct {
    int         pos;
    logic [2:0] ctl;
    logic       sf;
    logic       rdy;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] bar_col(input int i);
    case (i)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic fill_sel(input logic en);
    return en;
  endfunction

  // Reference for the 16x8 raster: {DE,HSYNC,VSYNC} at position p of the frame
  function automatic logic [2:0] ctl_model(input int p);
    int h;
    int v;
    h = p % 16;
    v = (p / 16) % 8;
    return {(h < 8) && (v < 4), (h >= 10) && (h < 12), (v == 5)};
  endfunction

  task automatic hold_reset();
    @(negedge clk);
    resetq = 1'b0;
    valid  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Called right after reset release (before the first edge); k-th edge registers position k
  task automatic run_small(input int ncyc, input int drop_a, input int drop_b,
                           input logic [23:0] base, input bit use_tab);
    logic [23:0] data;
    logic        uf_m;
    data  = base;
    uf_m  = 1'b0;
    valid = (drop_a != 0) && (drop_b != 0);
    rgb   = data;
    for (int k = 0; k < ncyc; k++) begin
      logic [2:0]  c;
      logic [23:0] exp_rgb;
      @(posedge clk);
      #1;
      c = ctl_model(k);
      if (c[2]) exp_rgb = valid ? data : (fill_sel(CB_EN) ? bar_col(k % 16) : 24'h0);
      else      exp_rgb = 24'h0;
      if (c[2] && !valid) uf_m = 1'b1;
      else if (k % 128 == 0) uf_m = 1'b0;
      chk($sformatf("dd1@%0d", k), 32'(dd1), 32'({exp_rgb, c}));
      chk($sformatf("sof@%0d", k), 32'(sof), 32'(k % 128 == 0));
      chk($sformatf("underflow@%0d", k), 32'(uf), 32'(uf_m));
      chk($sformatf("ready@%0d", k + 1), 32'(ready), 32'(ctl_model(k + 1) >> 2));
      if (use_tab) begin
        for (int i = 0; i < NV; i++) begin
          if (vecs[i].pos == k) begin
            chk($sformatf("tab_ctl@%0d", k), 32'(dd1[2:0]), 32'(vecs[i].ctl));
            chk($sformatf("tab_sof@%0d", k), 32'(sof), 32'(vecs[i].sf));
            chk($sformatf("tab_rdy@%0d", k), 32'(ready), 32'(vecs[i].rdy));
          end
        end
      end
      if (c[2] && valid) data = data + 24'd1;
      valid = !((k + 1 == drop_a) || (k + 1 == drop_b));
      rgb   = data;
    end
  endtask

  initial begin
    int k1;
    int k2;
    logic prev;

    vecs[0]  = '{0,   3'b100, 1'b1, 1'b1};
    vecs[1]  = '{7,   3'b100, 1'b0, 1'b0};
    vecs[2]  = '{8,   3'b000, 1'b0, 1'b0};
    vecs[3]  = '{10,  3'b010, 1'b0, 1'b0};
    vecs[4]  = '{11,  3'b010, 1'b0, 1'b0};
    vecs[5]  = '{12,  3'b000, 1'b0, 1'b0};
    vecs[6]  = '{15,  3'b000, 1'b0, 1'b1};
    vecs[7]  = '{16,  3'b100, 1'b0, 1'b1};
    vecs[8]  = '{55,  3'b100, 1'b0, 1'b0};
    vecs[9]  = '{63,  3'b000, 1'b0, 1'b0};
    vecs[10] = '{64,  3'b000, 1'b0, 1'b0};
    vecs[11] = '{80,  3'b001, 1'b0, 1'b0};
    vecs[12] = '{90,  3'b011, 1'b0, 1'b0};
    vecs[13] = '{95,  3'b001, 1'b0, 1'b0};
    vecs[14] = '{96,  3'b000, 1'b0, 1'b0};
    vecs[15] = '{127, 3'b000, 1'b0, 1'b1};
    vecs[16] = '{128, 3'b100, 1'b1, 1'b1};

    resetq   = 1'b0;
    valid    = 1'b0;
    rgb      = 24'h0;
    cb_rgb   = 24'h123456;
    cb_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dd1", 32'(dd1), 32'h0);
    chk("rst_sof", 32'(sof), 32'h0);
    chk("rst_underflow", 32'(uf), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_cb_ready", 32'(cb_ready), 32'h1);
    chk("rst_hd_ready", 32'(hd_ready), 32'h1);

    // Clean frames with incrementing pixels
    resetq = 1'b1;
    run_small(260, -1, -1, 24'h000001, 1'b1);

    // Underflow on the 3rd pixel of line 0, then in the sof cycle itself
    hold_reset();
    resetq = 1'b1;
    run_small(260, 2, 128, 24'hA00000, 1'b0);

    // Mid-frame reset at hc=5, vc=2 with underflow already set
    hold_reset();
    resetq = 1'b1;
    run_small(37, 3, -1, 24'h100000, 1'b0);
    #2;
    resetq = 1'b0;
    #1;
    chk("midrst_dd1", 32'(dd1), 32'h0);
    chk("midrst_sof", 32'(sof), 32'h0);
    chk("midrst_underflow", 32'(uf), 32'h0);
    chk("midrst_ready", 32'(ready), 32'h1);
    @(negedge clk);
    resetq = 1'b1;
    run_small(20, -1, -1, 24'h200000, 1'b0);

    // Fill colour on a 16-pixel line with no valid input
    hold_reset();
    resetq = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      if (k < 16) begin
        chk($sformatf("cb_rgb@%0d", k), 32'(cb_dd1[26:3]),
            32'(fill_sel(CB_EN) ? bar_col(k / 2) : 24'h0));
        chk($sformatf("cb_de@%0d", k), 32'(cb_dd1[2]), 32'h1);
      end else begin
        chk($sformatf("cb_blank@%0d", k), 32'(cb_dd1[26:2]), 32'h0);
      end
    end

    // 720p line period from HSYNC rising edges, bounded wait
    hold_reset();
    resetq = 1'b1;
    valid  = 1'b1;
    k1     = -1;
    k2     = -1;
    prev   = 1'b0;
    for (int k = 0; (k < 4000) && (k2 < 0); k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        chk("hd_first_ctl", 32'(hd_dd1[2:0]), 32'h4);
        chk("hd_first_sof", 32'(hd_sof), 32'h1);
      end
      if (hd_dd1[1] && !prev) begin
        if (k1 < 0) k1 = k;
        else        k2 = k;
      end
      prev = hd_dd1[1];
    end
    chk("hd_hs_first", 32'(k1), 32'd1390);
    chk("hd_hs_period", 32'(k2 - k1), 32'd1650);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 H_ACTIVE, default 1280: active pixels per line.
REQ-002 H_FP, default 110: horizontal front porch, in clocks.
REQ-003 H_SYNC, default 40: HSYNC pulse width, in clocks.
REQ-004 H_BP, default 220: horizontal back porch, in clocks; must be >= 64 so the downstream HDMI encoder's data island and guards fit.
REQ-005 V_ACTIVE / V_FP / V_SYNC / V_BP, defaults 720 / 5 / 5 / 20: the same four quantities in lines.
REQ-006 clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 resetq  in  1  reset, asynchronous assert, active-low.
REQ-008 pix_rgb  in  24  upstream pixel as {R[7:0],G[7:0],B[7:0]}.
REQ-009 pix_valid  in  1  pix_rgb holds a valid pixel.
REQ-010 pix_ready  out  1  block takes a pixel this cycle; a transfer occurs when pix_valid & pix_ready.
REQ-011 dd1  out  27  registered video bus {R,G,B,DE,HSYNC,VSYNC} feeding the HDMI encoder.
REQ-012 sof  out  1  registered one-cycle pulse, coincident with dd1 carrying pixel (0,0).
REQ-013 underflow  out  1  sticky flag: an active pixel was emitted without a valid input.

Function
REQ-014 Horizontal counter hc runs 0..H_TOTAL-1 with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, then wraps to 0.
REQ-015 Vertical counter vc increments when hc wraps; vc runs 0..V_TOTAL-1 with the same four-term sum, then wraps to 0.
REQ-016 Counter region order: active, then front porch, then sync, then back porch.
REQ-017 DE=1 iff hc<H_ACTIVE and vc<V_ACTIVE.
REQ-018 HSYNC=1 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; HSYNC is active-high on every line, including vertical blanking.
REQ-019 VSYNC=1 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; VSYNC changes only on the cycle where hc=0.
REQ-020 Latency: dd1, sof and underflow are registered; the values computed from (hc,vc) in cycle n appear on the outputs in cycle n+1.
REQ-021 pix_ready is combinational and equals the DE term computed for the current (hc,vc).
REQ-022 pix_ready does not depend on pix_valid, and pix_valid does not stall the counters; timing is free-running.
REQ-023 Active cycle with pix_valid=1: dd1 RGB = pix_rgb.
REQ-024 Active cycle with pix_valid=0: dd1 RGB = fill colour (REQ-032/033), and underflow sets on the following edge.
REQ-025 Blanking cycle: dd1 RGB = 0, and pix_rgb is ignored.
REQ-026 sof is registered high for exactly one cycle per frame, when the source position is hc=0, vc=0.
REQ-027 underflow clears on the same edge that asserts sof; if an underflow occurs in the sof cycle itself, the set wins.

Reset
REQ-028 While resetq=0: hc=0, vc=0, dd1=0, sof=0, underflow=0; pix_ready=1, because the counters sit at (0,0).
REQ-029 The first rising edge after resetq deasserts registers pixel (0,0); dd1 DE=1 and sof=1 on that cycle.
REQ-030 Asserting reset mid-frame abandons the frame immediately; no partial-line completion.

Configuration
REQ-031 Macro VIDEO_TIMING_COLORBAR_EN selects the fill colour used on underflow.
REQ-032 With VIDEO_TIMING_COLORBAR_EN defined: fill is 8 vertical bars left to right: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Each bar is H_ACTIVE/8 pixels wide (integer division).
  - Any pixels remaining after the 8th bar are black.
  - Implemented with a bar counter and a position counter reset at hc=0; no divider.
REQ-033 Without VIDEO_TIMING_COLORBAR_EN: fill is 000000, and no bar logic is synthesised.

Verification
REQ-034 Small timing (H 8/2/2/4, V 4/1/1/2), pix_valid=1 with incrementing pix_rgb -> H_TOTAL=16, V_TOTAL=8.
  - DE high for 8 consecutive cycles per line on 4 lines.
  - HSYNC high at hc 10-11.
  - VSYNC high on line 5 only.
  - sof every 128 cycles.
REQ-035 Release reset -> dd1[2:0]=3'b100 and sof=1 on the first edge; pixels consumed in order with no gaps; pix_ready=0 during all blanking cycles.
REQ-036 Drop pix_valid for the 3rd pixel of line 0 -> that output is fill colour, underflow=1 from the next cycle until the next sof, then 0.
REQ-037 COLORBAR_EN defined, H_ACTIVE=16, pix_valid=0 -> each line shows 2 pixels each of FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; without the macro, all pixels are 000000.
REQ-038 Assert resetq=0 at hc=5, vc=2 -> outputs go to 0 asynchronously; after release, the frame restarts at (0,0) with sof=1.
REQ-039 Default 720p parameters -> 1650 clocks per line and 750 lines per frame; HSYNC rising edges are exactly 1650 clocks apart.
